branch_predict_unit: RTL
========================

# branch_predict_unit

Parametrised branch resolution and prediction unit for the RV32I pipeline. Fetch indexes a branch history table (BHT) of 2-bit saturating counters to predict taken or not-taken. Execute resolves the real outcome from the ALU comparison flags and funct3, then flags a mispredict. One cycle later the BHT updates and the performance counters advance. It replaces the purely combinational branch condition check in the execute stage.

## Interface
Parameters:
- XLEN, 32, PC width.
- BHT_ENTRIES, 64, number of counters; power of two, 2..1024.
- IDX_W, $clog2(BHT_ENTRIES), derived; not overridden.
- CNT_W, 32, width of each performance counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- pc_f  in  XLEN  fetch PC.
- predict_taken_f  out  1  combinational prediction for pc_f; equals the MSB of BHT[pc_f[IDX_W+1:2]].
- resolve_valid  in  1  execute holds a conditional branch this cycle.
- pc_e  in  XLEN  PC of the resolving branch.
- funct3_e  in  3  branch funct3.
- equal, less_than, less_than_unsigned  in  1 each  ALU comparison flags.
- predicted_taken_e  in  1  prediction carried down the pipe with the branch.
- branch_taken  out  1  combinational resolved outcome.
- mispredict  out  1  combinational; resolve_valid & legal & (branch_taken != predicted_taken_e).
- illegal_branch  out  1  combinational; resolve_valid & funct3_e in {010, 011}.
- branch_count  out  CNT_W  registered count of legal resolved branches.
- mispredict_count  out  CNT_W  registered count of mispredicts.

## Operation
- Condition evaluation by funct3:
  - 000 taken if equal.
  - 001 taken if !equal.
  - 100 taken if less_than.
  - 101 taken if !less_than.
  - 110 taken if less_than_unsigned.
  - 111 taken if !less_than_unsigned.
  - 010 and 011 are illegal: branch_taken=0, mispredict=0, no BHT or counter update.
- branch_taken is 0 whenever resolve_valid=0.
- Index: idx = pc[IDX_W+1:2]. The low two PC bits are ignored and the upper bits alias.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Update on a legal resolve:
  - taken: counter increments, saturating at 11.
  - not taken: counter decrements, saturating at 00.
- Update is captured at the clock edge ending the resolve cycle. Only one entry is written per cycle.
- branch_count increments on each legal resolve. mispredict_count increments on each mispredict. Both wrap modulo 2^CNT_W.

## Timing
- Prediction and resolution outputs have zero latency and are combinational.
- BHT write and counter increments become visible one cycle after the resolve cycle.
- Same-index read/write collision: a fetch read in the same cycle as a resolve to the same index returns the pre-update value. The new value is seen from the next cycle.
- Back-to-back resolves to the same index each see the previously written value. No update may be lost.
- Reset:
  - all BHT entries go to 01 (weak-NT), so predict_taken_f=0 for every PC;
  - branch_count and mispredict_count go to 0.
- Reset asserted mid-operation aborts any pending update immediately. The first edge after deassertion performs normal updates.
- No state machine beyond the per-entry counters. No stall input: the pipeline withholds resolve_valid during stalls and flushes.

## Structure
- Package branch_pkg:
  - funct3 constants BEQ, BNE, BLT, BGE, BLTU, BGEU;
  - typedef enum logic [1:0] bht_state_t {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T};
  - function sat_update(bht_state_t, logic taken).
- Sub-module branch_cond_eval: combinational funct3 and flag evaluation producing taken and legal.
- Top level holds the BHT array, the update logic and the performance counters.

## Test plan
- Reset, then pc_f=0x100 → predict_taken_f=0. Both counters read 0.
- Four resolves of BEQ at pc_e=0x100 with equal=1 and predicted_taken_e tracking the prediction:
  - predictions seen in fetch follow 0,1,1,1;
  - mispredict pulses once;
  - final state is STRONG_T;
  - branch_count=4, mispredict_count=1.
- All six legal funct3 values × flag combinations → branch_taken matches the rule list. funct3=010 with resolve_valid=1 → illegal_branch=1, counters unchanged.
- Resolve at pc_e=0x200 (taken) with pc_f=0x200 in the same cycle → predict_taken_f shows the old value, the new value on the next cycle.
- Aliasing with BHT_ENTRIES=16: PCs 0x004 and 0x044 share an entry. Training one flips the other's prediction.
- Counters preloaded near wrap with CNT_W=4: the 16th legal resolve → branch_count=0. Assert rst_n low mid-burst → all state returns to reset values asynchronously.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and helpers for branch resolution and prediction.
// Holds RV32I branch funct3 codes, the 2-bit BHT counter type and its saturating update.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bht_state_t;

  // Two-bit saturating counter: step towards taken or not-taken, clamp at the ends.
  function automatic bht_state_t sat_update(input bht_state_t state, input logic taken);
    bht_state_t result;
    result = state;
    unique case (state)
      STRONG_NT: result = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   result = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    result = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  result = taken ? STRONG_T : WEAK_T;
      default:   result = state;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation from funct3 and the ALU comparison flags.
// funct3 010/011 are not branch encodings and report legal=0, taken=0.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       equal,
  input  logic       less_than,
  input  logic       less_than_unsigned,
  output logic       taken,
  output logic       legal
);

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    unique case (funct3)
      BEQ:     taken = equal;
      BNE:     taken = ~equal;
      BLT:     taken = less_than;
      BGE:     taken = ~less_than;
      BLTU:    taken = less_than_unsigned;
      BGEU:    taken = ~less_than_unsigned;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch history table of 2-bit counters with execute-stage resolution and
// mispredict detection; BHT and performance counters update on the edge ending a resolve.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_W       = $clog2(BHT_ENTRIES),  // derived, leave at default
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pc_f,
  output logic             predict_taken_f,
  input  logic             resolve_valid,
  input  logic [XLEN-1:0]  pc_e,
  input  logic [2:0]       funct3_e,
  input  logic             equal,
  input  logic             less_than,
  input  logic             less_than_unsigned,
  input  logic             predicted_taken_e,
  output logic             branch_taken,
  output logic             mispredict,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  logic             cond_taken;
  logic             cond_legal;
  logic             resolve_legal;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] upd_idx;
  bht_state_t       upd_state;
  bht_state_t       bht_reg [BHT_ENTRIES];
  logic [CNT_W-1:0] branch_count_reg;
  logic [CNT_W-1:0] mispredict_count_reg;

  // PC bits outside the index field are intentionally ignored (aliasing).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[XLEN-1:IDX_W+2], pc_f[1:0], pc_e[XLEN-1:IDX_W+2], pc_e[1:0]};

  branch_cond_eval u_cond_eval (
    .funct3             (funct3_e),
    .equal              (equal),
    .less_than          (less_than),
    .less_than_unsigned (less_than_unsigned),
    .taken              (cond_taken),
    .legal              (cond_legal)
  );

  assign resolve_legal  = resolve_valid & cond_legal;
  assign branch_taken   = resolve_legal & cond_taken;
  assign mispredict     = resolve_legal & (branch_taken != predicted_taken_e);
  assign illegal_branch = resolve_valid & ~cond_legal;

  assign fetch_idx       = pc_f[IDX_W+1:2];
  assign upd_idx         = pc_e[IDX_W+1:2];
  assign predict_taken_f = bht_reg[fetch_idx][1];
  assign upd_state       = sat_update(bht_reg[upd_idx], cond_taken);

  // Per-entry registers: the fetch read sees the pre-update value on a same-index collision.
  generate
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bht_reg[gi] <= WEAK_NT;
        end else if (resolve_legal && (upd_idx == IDX_W'(gi))) begin
          bht_reg[gi] <= upd_state;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (resolve_legal) branch_count_reg <= branch_count_reg + 1'b1;
      if (mispredict)    mispredict_count_reg <= mispredict_count_reg + 1'b1;
    end
  end

  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule
